pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage of the single-cycle MIPS core. It holds the architectural PC, computes PC+4, and selects the next PC from four sources: sequential, conditional branch, J-type jump, or register jump. The branch offset input is the 32-bit sign-extended immediate from the immediate extender. The block also has a boot-hold phase, a halt state, a misaligned-target fault, and a retired-instruction counter.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- BOOT_DELAY, 2, cycles after reset release during which fetch is held invalid; range 0..15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC; no advance, no retire.
- halt  input  1  enter HALTED; priority over stall.
- branch_taken  input  1  conditional branch resolved taken this cycle.
- branch_offset  input  32  sign-extended 16-bit immediate (word offset).
- jump  input  1  J/JAL this cycle.
- jump_index  input  26  instruction[25:0].
- jump_reg  input  1  JR/JALR this cycle.
- jump_reg_addr  input  32  rs value.
- pc  output  32  current PC, registered.
- pc_plus4  output  32  pc + 4, combinational (JAL link value).
- pc_valid  output  1  PC is a valid fetch address this cycle.
- misalign_fault  output  1  sticky; set on a misaligned redirect.
- retired_count  output  32  count of PC advances in RUN.

## Operation
- States: BOOT, RUN, HALTED, FAULT.
- BOOT:
  - pc = RESET_VECTOR, pc_valid = 0, boot counter increments each cycle.
  - Moves to RUN when the counter reaches BOOT_DELAY. With BOOT_DELAY = 0, RUN is entered on the first edge after reset release.
  - All control inputs are ignored.
- RUN, evaluated in this priority order:
  1. halt: go to HALTED, pc holds.
  2. stall: pc and retired_count hold.
  3. Otherwise pc <= next_pc and retired_count increments.
- next_pc priority: jump_reg > jump > branch_taken > sequential.
  - jump_reg target = jump_reg_addr.
  - jump target = {pc_plus4[31:28], jump_index, 2'b00}.
  - branch target = pc_plus4 + (branch_offset << 2).
  - sequential = pc_plus4.
- All 32-bit arithmetic wraps modulo 2^32. pc = 32'hFFFF_FFFC gives pc_plus4 = 0.
- If the selected target has bits [1:0] != 0 (possible only via jump_reg):
  - Go to FAULT; pc holds its current value and retired_count does not increment.
  - misalign_fault sets to 1.
- HALTED and FAULT are terminal until reset:
  - pc holds, pc_valid = 0, retired_count holds.
  - misalign_fault stays 1 in FAULT.
- pc_valid = 1 only in RUN, including stalled cycles.
- retired_count wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset, asserted asynchronously at any time including mid-redirect:
  - pc = RESET_VECTOR, state = BOOT, boot counter = 0.
  - pc_valid = 0, misalign_fault = 0, retired_count = 0.
- Redirect latency is one cycle. Controls sampled at edge N appear on pc after edge N.
- halt sampled at edge N: pc_valid = 0 after edge N.
- Simultaneous halt and jump_reg with a misaligned address: HALTED wins and no fault is raised.
- Simultaneous stall and any redirect: stall wins and the redirect is dropped. The upstream logic must hold its controls until stall deasserts.
- The first fetch address after BOOT is RESET_VECTOR, with pc_valid = 1 on that cycle.

## Structure
- Shared package mips_pkg:
  - pc_state_t enum (BOOT, RUN, HALTED, FAULT).
  - PC_STEP = 4.
  - Default RESET_VECTOR constant.
- Sub-module next_pc_mux (combinational):
  - Takes pc_plus4, the control bits, branch_offset, jump_index and jump_reg_addr.
  - Returns next_pc and a misaligned flag.
- pc_unit holds the state register, the PC register, the boot counter and the retired counter.

## Test plan
- Reset with BOOT_DELAY = 2 -> pc = 0 and pc_valid = 0 for 2 cycles, then pc_valid = 1; pc steps 0, 4, 8 and retired_count reaches 2 after two advances.
- pc = 32'h100, branch_taken, branch_offset = 32'hFFFF_FFFE -> next pc = 32'h0FC. Then branch_offset = 32'h0000_0010 at pc 32'h0FC -> 32'h140.
- pc = 32'h3000_0010, jump with jump_index = 26'h000_0040 together with branch_taken -> pc = 32'h3000_0100 (jump wins).
- jump_reg with jump_reg_addr = 32'h0000_2002 -> FAULT, misalign_fault = 1, pc unchanged, pc_valid = 0. Reset then clears the fault.
- stall held 3 cycles with jump asserted -> pc and retired_count frozen; after stall drops with jump still asserted, the jump target is taken.
- halt together with stall at pc = 32'h40 -> HALTED, pc = 32'h40 held, pc_valid = 0. Asserting reset mid-HALTED -> pc = RESET_VECTOR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } pc_state_t;

   localparam logic [31:0] PC_STEP              = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: register jump > J-type jump > taken branch > sequential.
module next_pc_mux (
   input  logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] jump_reg_addr,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   always_comb begin
      next_pc = pc_plus4;
      if (jump_reg) begin
         next_pc = jump_reg_addr;
      end else if (jump) begin
         next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      end else if (branch_taken) begin
         // word offset scaled to bytes; top two offset bits fall off with the wrap
         next_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
      end
   end

   // only a register jump can produce a non-word-aligned target
   assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, boot hold, halt/fault handling, retire counter.
//
// state  | meaning
// BOOT   | fetch held invalid while the boot counter runs; controls ignored
// RUN    | PC advances/redirects each unstalled cycle; fetch valid
// HALTED | terminal after halt; PC and counter frozen until reset
// FAULT  | terminal after a misaligned redirect; misalign_fault held high
module pc_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned BOOT_DELAY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        halt,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] jump_reg_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        pc_valid,
   output logic        misalign_fault,
   output logic [31:0] retired_count
);

   // BOOT exits on the edge where the incremented count would reach BOOT_DELAY;
   // a delay of 0 behaves like 1 (one invalid cycle before the first edge).
   localparam logic [4:0] BOOT_LAST = (BOOT_DELAY == 0) ? 5'd0 : 5'(BOOT_DELAY - 1);

   pc_state_t   state, state_nx;
   logic [31:0] pc_q, pc_nx;
   logic [3:0]  boot_cnt, boot_cnt_nx;
   logic [31:0] retired_q, retired_nx;
   logic        fault_q, fault_nx;
   logic [31:0] next_pc;
   logic        misaligned;
   logic        boot_done;

   assign pc_plus4  = pc_q + PC_STEP;
   assign boot_done = ({1'b0, boot_cnt} >= BOOT_LAST);

   next_pc_mux u_next_pc_mux (
      .pc_plus4      (pc_plus4),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_index    (jump_index),
      .jump_reg      (jump_reg),
      .jump_reg_addr (jump_reg_addr),
      .next_pc       (next_pc),
      .misaligned    (misaligned)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= BOOT;
         pc_q      <= RESET_VECTOR;
         boot_cnt  <= '0;
         retired_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state     <= state_nx;
         pc_q      <= pc_nx;
         boot_cnt  <= boot_cnt_nx;
         retired_q <= retired_nx;
         fault_q   <= fault_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      pc_nx       = pc_q;
      boot_cnt_nx = boot_cnt;
      retired_nx  = retired_q;
      fault_nx    = fault_q;
      case (state)
         BOOT: begin
            boot_cnt_nx = boot_cnt + 4'd1;
            if (boot_done) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            // halt outranks stall, and both outrank a misaligned redirect
            if (halt) begin
               state_nx = HALTED;
            end else if (!stall) begin
               if (misaligned) begin
                  state_nx = FAULT;
                  fault_nx = 1'b1;
               end else begin
                  pc_nx      = next_pc;
                  retired_nx = retired_q + 32'd1;
               end
            end
         end
         default: ;
      endcase
   end

   assign pc             = pc_q;
   assign pc_valid       = (state == RUN);
   assign misalign_fault = fault_q;
   assign retired_count  = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, corner-case sequences, random vs. reference model.
module tb_pc_unit;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam int unsigned BD = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, halt, branch_taken, jump, jump_reg;
   logic [31:0] branch_offset, jump_reg_addr;
   logic [25:0] jump_index;
   logic [31:0] pc, pc_plus4, retired_count;
   logic        pc_valid, misalign_fault;

   int errors = 0;
   int checks = 0;

   pc_unit #(.RESET_VECTOR(RV), .BOOT_DELAY(BD)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .halt           (halt),
      .branch_taken   (branch_taken),
      .branch_offset  (branch_offset),
      .jump           (jump),
      .jump_index     (jump_index),
      .jump_reg       (jump_reg),
      .jump_reg_addr  (jump_reg_addr),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .pc_valid       (pc_valid),
      .misalign_fault (misalign_fault),
      .retired_count  (retired_count)
   );

   always #5 clk = ~clk;

   // Reference model: an abstract "mode" (booting / running / stopped) plus
   // the architectural PC and count, updated from the block's rules.
   logic [31:0] m_pc, m_cnt, m_p4, m_t;
   int          m_boot_wait;
   bit          m_run, m_stop, m_fault;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc        = RV;
         m_cnt       = 32'd0;
         m_boot_wait = (BD == 0) ? 1 : int'(BD);
         m_run       = 1'b0;
         m_stop      = 1'b0;
         m_fault     = 1'b0;
      end else if (!m_run && !m_stop) begin
         m_boot_wait = m_boot_wait - 1;
         if (m_boot_wait == 0) m_run = 1'b1;
      end else if (m_run) begin
         if (halt) begin
            m_run  = 1'b0;
            m_stop = 1'b1;
         end else if (!stall) begin
            m_p4 = m_pc + 32'd4;
            if (jump_reg)          m_t = jump_reg_addr;
            else if (jump)         m_t = (m_p4 & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
            else if (branch_taken) m_t = m_p4 + branch_offset * 32'd4;
            else                   m_t = m_p4;
            if (m_t % 32'd4 != 32'd0) begin
               m_run   = 1'b0;
               m_stop  = 1'b1;
               m_fault = 1'b1;
            end else begin
               m_pc  = m_t;
               m_cnt = m_cnt + 32'd1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      stall         = 1'b0;
      halt          = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 32'd0;
      jump          = 1'b0;
      jump_index    = 26'd0;
      jump_reg      = 1'b0;
      jump_reg_addr = 32'd0;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " pc"},       pc,                    m_pc);
      chk({tag, " pc_plus4"}, pc_plus4,              m_pc + 32'd4);
      chk({tag, " valid"},    {31'd0, pc_valid},     {31'd0, m_run});
      chk({tag, " fault"},    {31'd0, misalign_fault}, {31'd0, m_fault});
      chk({tag, " retired"},  retired_count,         m_cnt);
   endtask

   // reset asserted mid-cycle, checked before any edge, released after one edge
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      chk({tag, " async pc"},    pc,                 RV);
      chk({tag, " async valid"}, {31'd0, pc_valid},  32'd0);
      chk({tag, " async fault"}, {31'd0, misalign_fault}, 32'd0);
      chk({tag, " async cnt"},   retired_count,      32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic        halt, stall, br, jmp, jr;
      logic [31:0] off;
      logic [25:0] idx;
      logic [31:0] jaddr;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic h, input logic s, input logic b, input logic j,
                               input logic r, input logic [31:0] off, input logic [25:0] idx,
                               input logic [31:0] jaddr, input logic [31:0] e_pc,
                               input logic e_valid, input logic [31:0] e_cnt);
      vec_t v;
      v.halt = h; v.stall = s; v.br = b; v.jmp = j; v.jr = r;
      v.off = off; v.idx = idx; v.jaddr = jaddr;
      v.e_pc = e_pc; v.e_valid = e_valid; v.e_cnt = e_cnt;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      //            h  s  b  j  r  offset         idx         jaddr          exp pc         v  cnt
      tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,         26'h0,      32'h0,         32'h0,         0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0,         26'h0,      32'h0,         32'h0,         1, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,         26'h0,      32'h0,         32'h4,         1, 1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0,         26'h0,      32'h0,         32'h8,         1, 2);
      tbl[4]  = mk(0, 0, 0, 0, 1, 32'h0,         26'h0,      32'h100,       32'h100,       1, 3);
      tbl[5]  = mk(0, 0, 1, 0, 0, 32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0FC,       1, 4);
      tbl[6]  = mk(0, 0, 1, 0, 0, 32'h0000_0010, 26'h0,      32'h0,         32'h140,       1, 5);
      tbl[7]  = mk(0, 0, 0, 0, 1, 32'h0,         26'h0,      32'h3000_0010, 32'h3000_0010, 1, 6);
      tbl[8]  = mk(0, 0, 1, 1, 0, 32'h0000_0010, 26'h40,     32'h0,         32'h3000_0100, 1, 7);
      tbl[9]  = mk(0, 1, 0, 1, 0, 32'h0,         26'h80,     32'h0,         32'h3000_0100, 1, 7);
      tbl[10] = mk(0, 1, 0, 1, 0, 32'h0,         26'h80,     32'h0,         32'h3000_0100, 1, 7);
      tbl[11] = mk(0, 1, 0, 1, 0, 32'h0,         26'h80,     32'h0,         32'h3000_0100, 1, 7);
      tbl[12] = mk(0, 0, 0, 1, 0, 32'h0,         26'h80,     32'h0,         32'h3000_0200, 1, 8);
      tbl[13] = mk(0, 0, 0, 0, 1, 32'h0,         26'h0,      32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 9);
      tbl[14] = mk(0, 0, 0, 0, 0, 32'h0,         26'h0,      32'h0,         32'h0,         1, 10);
      tbl[15] = mk(0, 0, 0, 0, 1, 32'h0,         26'h0,      32'h40,        32'h40,        1, 11);
      tbl[16] = mk(1, 1, 0, 0, 0, 32'h0,         26'h0,      32'h0,         32'h40,        0, 11);
      tbl[17] = mk(0, 0, 0, 0, 1, 32'h0,         26'h0,      32'h2002,      32'h40,        0, 11);

      clear_ctl();
      reset = 1'b0;
      #1 reset = 1'b1;
      #10;
      chk("reset pc",    pc,                32'h0);
      chk("reset valid", {31'd0, pc_valid}, 32'd0);
      chk("reset cnt",   retired_count,     32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         halt          = tbl[i].halt;
         stall         = tbl[i].stall;
         branch_taken  = tbl[i].br;
         jump          = tbl[i].jmp;
         jump_reg      = tbl[i].jr;
         branch_offset = tbl[i].off;
         jump_index    = tbl[i].idx;
         jump_reg_addr = tbl[i].jaddr;
         tick();
         chk($sformatf("vec%0d pc", i),       pc,                tbl[i].e_pc);
         chk($sformatf("vec%0d pc_plus4", i), pc_plus4,          tbl[i].e_pc + 32'd4);
         chk($sformatf("vec%0d valid", i),    {31'd0, pc_valid}, {31'd0, tbl[i].e_valid});
         chk($sformatf("vec%0d cnt", i),      retired_count,     tbl[i].e_cnt);
         chk($sformatf("vec%0d fault", i),    {31'd0, misalign_fault}, 32'd0);
      end

      // still HALTED; reset mid-cycle must return pc to the vector at once
      clear_ctl();
      do_reset("halted");
      tick();
      tick();
      chk("reboot valid", {31'd0, pc_valid}, 32'd1);
      chk("reboot pc",    pc,                RV);

      // misaligned register jump -> FAULT, pc and count frozen
      jump_reg = 1'b1; jump_reg_addr = 32'h100;
      tick();
      jump_reg_addr = 32'h2002;
      tick();
      clear_ctl();
      chk("fault flag",  {31'd0, misalign_fault}, 32'd1);
      chk("fault pc",    pc,                32'h100);
      chk("fault valid", {31'd0, pc_valid}, 32'd0);
      chk("fault cnt",   retired_count,     32'd1);
      tick();
      chk("fault sticky", {31'd0, misalign_fault}, 32'd1);
      chk("fault pc2",    pc,                32'h100);
      do_reset("fault");
      tick();
      tick();

      // halt together with a misaligned register jump: halt wins, no fault
      halt = 1'b1; jump_reg = 1'b1; jump_reg_addr = 32'h2003;
      tick();
      clear_ctl();
      chk("halt+jr fault", {31'd0, misalign_fault}, 32'd0);
      chk("halt+jr valid", {31'd0, pc_valid},       32'd0);
      chk("halt+jr pc",    pc,                      RV);

      // randomized segments against the reference model
      for (int seg = 0; seg < 6; seg++) begin
         do_reset($sformatf("seg%0d", seg));
         for (int c = 0; c < 70; c++) begin
            logic [31:0] r;
            r             = $urandom;
            halt          = ($urandom_range(0, 79) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = r[20];
            branch_offset = {{16{r[15]}}, r[15:0]};
            jump          = ($urandom_range(0, 3) == 0);
            jump_index    = 26'($urandom);
            jump_reg      = ($urandom_range(0, 5) == 0);
            jump_reg_addr = $urandom;
            if ($urandom_range(0, 9) != 0) jump_reg_addr[1:0] = 2'b00;
            tick();
            chk_model($sformatf("rand%0d.%0d", seg, c));
         end
         clear_ctl();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
